// File: rtl/oram_host_sequencer.sv
// oram_host_sequencer
// Host-side front end for the PathORAM top. Accepts one whole-block host
// request at a time, screens its address, hands the command to the ORAM top,
// then streams write beats through (or discards them for rejected writes) and
// gathers read beats into a one-entry registered host output stage.

module oram_host_sequencer #(
   parameter int ORAMU         = 32,
   parameter int ORAMB         = 512,
   parameter int FEDWidth      = 64,
   parameter int BECMDWidth    = 2,
   parameter int NumValidBlock = 1024
) (
   input  logic                  Clock,
   input  logic                  Reset,

   // host command channel
   input  logic [BECMDWidth-1:0] HostCmd,
   input  logic [ORAMU-1:0]      HostAddr,
   input  logic                  HostCmdValid,
   output logic                  HostCmdReady,

   // host write-beat channel
   input  logic [FEDWidth-1:0]   HostWData,
   input  logic                  HostWDataValid,
   output logic                  HostWDataReady,

   // host read-beat channel
   output logic [FEDWidth-1:0]   HostRData,
   output logic                  HostRDataValid,
   output logic                  HostRDataLast,
   input  logic                  HostRDataReady,

   // status
   output logic                  HostError,
   output logic [15:0]           ReqCount,

   // ORAM top command channel
   output logic [BECMDWidth-1:0] Cmd,
   output logic [ORAMU-1:0]      PAddr,
   output logic                  CmdValid,
   input  logic                  CmdReady,

   // ORAM top write-beat channel
   output logic [FEDWidth-1:0]   DataIn,
   output logic                  DataInValid,
   input  logic                  DataInReady,

   // ORAM top read-beat channel
   input  logic [FEDWidth-1:0]   ReturnData,
   input  logic                  ReturnDataValid,
   output logic                  ReturnDataReady
);

   // ------------------------------------------------------------------
   // Derived constants
   // ------------------------------------------------------------------
   localparam int Beats = ORAMB / FEDWidth;
   localparam int BeatW = (Beats > 1) ? $clog2(Beats) : 1;

   localparam logic [BeatW-1:0] LAST_BEAT  = BeatW'(Beats - 1);
   localparam logic [BeatW-1:0] BEAT_ONE   = BeatW'(1);
   localparam logic [BeatW-1:0] BEAT_ZERO  = '0;
   localparam logic [ORAMU-1:0] ADDR_LIMIT = ORAMU'(NumValidBlock);
   localparam logic [15:0]      COUNT_MAX  = 16'hFFFF;

   // FSM encoding
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WDATA = 3'd2;
   localparam logic [2:0] S_RDATA = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [2:0]            state_reg;
   logic [2:0]            state_next;
   logic [BeatW-1:0]      beat_reg;
   logic [BeatW-1:0]      beat_next;
   logic                  last_loaded_reg;
   logic                  last_loaded_next;

   logic [BECMDWidth-1:0] cmd_reg;
   logic [ORAMU-1:0]      paddr_reg;

   logic [FEDWidth-1:0]   rdata_reg;
   logic                  rvalid_reg;
   logic                  rlast_reg;

   logic                  error_reg;
   logic [15:0]           req_count_reg;

   // ------------------------------------------------------------------
   // Decoded conditions
   // ------------------------------------------------------------------
   logic in_idle;
   logic in_issue;
   logic in_wdata;
   logic in_rdata;
   logic in_drain;

   logic addr_ok;
   logic cmd_fire;
   logic issue_fire;
   logic wdata_fire;
   logic drain_fire;
   logic rdata_load;
   logic host_take;
   logic at_last_beat;
   logic complete;

   assign in_idle  = (state_reg == S_IDLE);
   assign in_issue = (state_reg == S_ISSUE);
   assign in_wdata = (state_reg == S_WDATA);
   assign in_rdata = (state_reg == S_RDATA);
   assign in_drain = (state_reg == S_DRAIN);

   assign addr_ok      = (HostAddr < ADDR_LIMIT);
   assign at_last_beat = (beat_reg == LAST_BEAT);

   // ------------------------------------------------------------------
   // Port-level handshakes
   // ------------------------------------------------------------------
   assign HostCmdReady    = in_idle;

   // Command is held for the whole ISSUE state; state is registered, so
   // CmdValid rises exactly one cycle after the host command is accepted.
   assign CmdValid        = in_issue;
   assign Cmd             = cmd_reg;
   assign PAddr           = paddr_reg;

   // Write beats pass straight through with no buffering; DRAIN swallows them.
   assign DataIn          = HostWData;
   assign DataInValid     = in_wdata & HostWDataValid;
   assign HostWDataReady  = (in_wdata & DataInReady) | in_drain;

   // One-entry output stage: room exists when empty or being emptied this
   // cycle. Once the final beat is held nothing more is taken from the top.
   assign ReturnDataReady = in_rdata & ~last_loaded_reg & (~rvalid_reg | HostRDataReady);

   assign HostRData       = rdata_reg;
   assign HostRDataValid  = rvalid_reg;
   assign HostRDataLast   = rlast_reg;
   assign HostError       = error_reg;
   assign ReqCount        = req_count_reg;

   assign cmd_fire   = HostCmdValid & in_idle;
   assign issue_fire = in_issue & CmdReady;
   assign wdata_fire = DataInValid & DataInReady;
   assign drain_fire = in_drain & HostWDataValid;
   assign rdata_load = ReturnDataValid & ReturnDataReady;
   assign host_take  = rvalid_reg & HostRDataReady;

   // Next-state, beat-counter and completion decode for the request FSM
   always_comb begin
      state_next       = state_reg;
      beat_next        = beat_reg;
      last_loaded_next = last_loaded_reg;
      complete         = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (cmd_fire) begin
               if (addr_ok) begin
                  state_next = S_ISSUE;
               end else if (!HostCmd[1]) begin
                  // rejected write still owes us a block of beats
                  state_next = S_DRAIN;
                  beat_next  = BEAT_ZERO;
               end
            end
         end

         S_ISSUE: begin
            if (issue_fire) begin
               beat_next        = BEAT_ZERO;
               last_loaded_next = 1'b0;
               state_next       = cmd_reg[1] ? S_RDATA : S_WDATA;
            end
         end

         S_WDATA: begin
            if (wdata_fire) begin
               if (at_last_beat) begin
                  beat_next  = BEAT_ZERO;
                  state_next = S_IDLE;
                  complete   = 1'b1;
               end else begin
                  beat_next  = beat_reg + BEAT_ONE;
               end
            end
         end

         S_RDATA: begin
            if (rdata_load) begin
               beat_next = beat_reg + BEAT_ONE;
               if (at_last_beat) begin
                  last_loaded_next = 1'b1;
               end
            end
            // final beat leaves the output stage: request is done
            if (host_take && rlast_reg) begin
               beat_next        = BEAT_ZERO;
               last_loaded_next = 1'b0;
               state_next       = S_IDLE;
               complete         = 1'b1;
            end
         end

         S_DRAIN: begin
            if (drain_fire) begin
               if (at_last_beat) begin
                  beat_next  = BEAT_ZERO;
                  state_next = S_IDLE;
               end else begin
                  beat_next  = beat_reg + BEAT_ONE;
               end
            end
         end

         default: begin
            state_next       = S_IDLE;
            beat_next        = BEAT_ZERO;
            last_loaded_next = 1'b0;
         end
      endcase
   end

   // FSM state and beat counter registers
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_reg       <= S_IDLE;
         beat_reg        <= BEAT_ZERO;
         last_loaded_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         beat_reg        <= beat_next;
         last_loaded_reg <= last_loaded_next;
      end
   end

   // Latch command and address of an accepted in-range request
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         cmd_reg   <= '0;
         paddr_reg <= '0;
      end else if (cmd_fire && addr_ok) begin
         cmd_reg   <= HostCmd;
         paddr_reg <= HostAddr;
      end
   end

   // Registered host read stage: load from the top, clear on host take
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         rdata_reg  <= '0;
         rvalid_reg <= 1'b0;
         rlast_reg  <= 1'b0;
      end else if (rdata_load) begin
         rdata_reg  <= ReturnData;
         rvalid_reg <= 1'b1;
         rlast_reg  <= at_last_beat;
      end else if (host_take) begin
         rvalid_reg <= 1'b0;
         rlast_reg  <= 1'b0;
      end
   end

   // One-cycle error pulse for an accepted out-of-range command
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         error_reg <= 1'b0;
      end else begin
         error_reg <= cmd_fire & ~addr_ok;
      end
   end

   // Saturating count of requests that reached the ORAM top and finished
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         req_count_reg <= '0;
      end else if (complete && (req_count_reg != COUNT_MAX)) begin
         req_count_reg <= req_count_reg + 16'd1;
      end
   end

endmodule

// File: tb/tb_oram_host_sequencer.sv
// tb_oram_host_sequencer
// Table of directed requests followed by randomized ones. Each request is
// driven at transaction level against a request-level model: expected
// ORAM-side and host-side beat streams, error pulse and completion count.

module tb_oram_host_sequencer;

   localparam int U     = 32;
   localparam int B     = 512;
   localparam int W     = 64;
   localparam int CW    = 2;
   localparam int NVB   = 1024;
   localparam int BEATS = B / W;

   logic          Clock = 1'b0;
   logic          Reset = 1'b0;
   logic [CW-1:0] HostCmd = '0;
   logic [U-1:0]  HostAddr = '0;
   logic          HostCmdValid = 1'b0;
   logic          HostCmdReady;
   logic [W-1:0]  HostWData = '0;
   logic          HostWDataValid = 1'b0;
   logic          HostWDataReady;
   logic [W-1:0]  HostRData;
   logic          HostRDataValid;
   logic          HostRDataLast;
   logic          HostRDataReady = 1'b0;
   logic          HostError;
   logic [15:0]   ReqCount;
   logic [CW-1:0] Cmd;
   logic [U-1:0]  PAddr;
   logic          CmdValid;
   logic          CmdReady = 1'b0;
   logic [W-1:0]  DataIn;
   logic          DataInValid;
   logic          DataInReady = 1'b0;
   logic [W-1:0]  ReturnData = '0;
   logic          ReturnDataValid = 1'b0;
   logic          ReturnDataReady;

   oram_host_sequencer #(
      .ORAMU(U), .ORAMB(B), .FEDWidth(W), .BECMDWidth(CW), .NumValidBlock(NVB)
   ) dut (
      .Clock(Clock), .Reset(Reset),
      .HostCmd(HostCmd), .HostAddr(HostAddr), .HostCmdValid(HostCmdValid),
      .HostCmdReady(HostCmdReady),
      .HostWData(HostWData), .HostWDataValid(HostWDataValid),
      .HostWDataReady(HostWDataReady),
      .HostRData(HostRData), .HostRDataValid(HostRDataValid),
      .HostRDataLast(HostRDataLast), .HostRDataReady(HostRDataReady),
      .HostError(HostError), .ReqCount(ReqCount),
      .Cmd(Cmd), .PAddr(PAddr), .CmdValid(CmdValid), .CmdReady(CmdReady),
      .DataIn(DataIn), .DataInValid(DataInValid), .DataInReady(DataInReady),
      .ReturnData(ReturnData), .ReturnDataValid(ReturnDataValid),
      .ReturnDataReady(ReturnDataReady)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [1:0]  cmd;
      logic [31:0] addr;
      int          pct;        // probability (%) of each valid/ready being high
      int          cmd_delay;  // cycles CmdReady is withheld while CmdValid
      logic [7:0]  stall_mask; // host stalls 2 cycles when beat i is presented
      bit          pattern;    // deterministic beat values
      bit          exp_err;    // expected HostError pulse
      bit          exp_issue;  // expected to reach the ORAM top
   } vec_t;

   vec_t vecs[9];
   int   total = 0;
   int   bad = 0;
   int   model_count = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   function automatic bit coin(input int pct);
      return ($urandom_range(99) < pct);
   endfunction

   task automatic idle_inputs();
      HostCmdValid    = 1'b0;
      HostWDataValid  = 1'b0;
      HostRDataReady  = 1'b0;
      CmdReady        = 1'b0;
      DataInReady     = 1'b0;
      ReturnDataValid = 1'b0;
   endtask

   // Drive one whole request on both sides and compare against the model.
   task automatic run_request(input int id, input vec_t v);
      logic [63:0] wq[BEATS];
      logic [63:0] rq[BEATS];
      logic [63:0] got_oram[$];
      logic [63:0] got_host[$];
      bit          got_last[$];
      bit          in_range;
      bit          is_write;
      bit [BEATS-1:0] stalled;
      int wi, ri, acc_iter, err_cycles, cv_cycles, issues;
      int host_w_acc, oram_r_acc, cv_after, first_rx, last_rx, done_iter;
      int stall_left, delay_left, mis, exp_n;
      bit cmd_bad, stall_bad, done, stalling;

      in_range = (v.addr < NVB);
      is_write = !v.cmd[1];
      for (int i = 0; i < BEATS; i++) begin
         wq[i] = v.pattern ? 64'(i) : {$urandom, $urandom};
         rq[i] = v.pattern ? 64'(32'hA0 + i) : {$urandom, $urandom};
      end
      wi = 0; ri = 0; acc_iter = -1; err_cycles = 0; cv_cycles = 0; issues = 0;
      host_w_acc = 0; oram_r_acc = 0; cv_after = -1; first_rx = -1; last_rx = -1;
      done_iter = -1; stall_left = 0; delay_left = v.cmd_delay;
      cmd_bad = 0; stall_bad = 0; done = 0; stalled = '0;

      for (int iter = 0; iter < 400 && !done; iter++) begin
         // drive
         HostCmdValid = (acc_iter < 0);
         HostCmd      = v.cmd;
         HostAddr     = v.addr;
         if (CmdValid && delay_left > 0) begin
            CmdReady = 1'b0;
            delay_left--;
         end else begin
            CmdReady = coin(v.pct);
         end
         DataInReady = coin(v.pct);
         if (is_write) begin
            HostWDataValid = (wi < BEATS) && coin(v.pct);
            HostWData      = (wi < BEATS) ? wq[wi] : 64'd0;
         end else begin
            HostWDataValid = coin(v.pct);
            HostWData      = {$urandom, $urandom};
         end
         if (!is_write) begin
            ReturnDataValid = (ri < BEATS) && coin(v.pct);
            ReturnData      = (ri < BEATS) ? rq[ri] : 64'd0;
         end else begin
            ReturnDataValid = coin(v.pct);
            ReturnData      = {$urandom, $urandom};
         end
         if (HostRDataValid && got_host.size() < BEATS && stall_left == 0
             && v.stall_mask[got_host.size()] && !stalled[got_host.size()]) begin
            stalled[got_host.size()] = 1'b1;
            stall_left = 2;
         end
         stalling = (stall_left > 0);
         if (stalling) begin
            HostRDataReady = 1'b0;
            stall_left--;
         end else begin
            HostRDataReady = coin(v.pct);
         end
         #1;
         // sample
         if (HostError) err_cycles++;
         if (CmdValid) begin
            cv_cycles++;
            if (Cmd !== v.cmd || PAddr !== v.addr) cmd_bad = 1;
         end
         if (acc_iter >= 0 && iter == acc_iter + 1) cv_after = int'(CmdValid);
         if (CmdValid && CmdReady) issues++;
         if (DataInValid && DataInReady) got_oram.push_back(DataIn);
         if (HostWDataValid && HostWDataReady) begin
            host_w_acc++;
            if (is_write) wi++;
         end
         if (ReturnDataValid && ReturnDataReady) begin
            oram_r_acc++;
            if (!is_write) ri++;
         end
         if (HostRDataValid && HostRDataReady) begin
            got_host.push_back(HostRData);
            got_last.push_back(HostRDataLast);
            if (first_rx < 0) first_rx = iter;
            last_rx = iter;
         end
         if (stalling && HostRDataValid && ReturnDataReady) stall_bad = 1;
         if (acc_iter >= 0 && iter > acc_iter && HostCmdReady) begin
            done = 1;
            done_iter = iter;
         end
         if (acc_iter < 0 && HostCmdReady) acc_iter = iter;
         tick();
      end
      idle_inputs();

      if (in_range) model_count++;

      check($sformatf("v%0d_done", id), done, 1);
      check($sformatf("v%0d_error_pulse", id), err_cycles, v.exp_err ? 1 : 0);
      check($sformatf("v%0d_issued", id), (cv_cycles > 0), v.exp_issue);
      if (in_range) begin
         check($sformatf("v%0d_cmd_latency", id), cv_after, 1);
         check($sformatf("v%0d_cmd_stable", id), cmd_bad, 0);
         check($sformatf("v%0d_cmd_handshakes", id), issues, 1);
      end
      // ORAM-side write beats
      exp_n = (is_write && in_range) ? BEATS : 0;
      mis = 0;
      for (int i = 0; i < got_oram.size() && i < exp_n; i++)
         if (got_oram[i] !== wq[i]) mis++;
      check($sformatf("v%0d_oram_wbeats", id), got_oram.size(), exp_n);
      check($sformatf("v%0d_oram_wdata", id), mis, 0);
      check($sformatf("v%0d_host_wbeats", id), host_w_acc, is_write ? BEATS : 0);
      check($sformatf("v%0d_oram_rbeats", id), oram_r_acc, (!is_write && in_range) ? BEATS : 0);
      // host-side read beats
      exp_n = (!is_write && in_range) ? BEATS : 0;
      mis = 0;
      for (int i = 0; i < got_host.size() && i < exp_n; i++) begin
         if (got_host[i] !== rq[i]) mis++;
         if (got_last[i] !== (i == BEATS - 1)) mis++;
      end
      check($sformatf("v%0d_host_rbeats", id), got_host.size(), exp_n);
      check($sformatf("v%0d_host_rdata_last", id), mis, 0);
      check($sformatf("v%0d_reqcount", id), ReqCount, model_count);
      if (v.stall_mask != 0 && !is_write && in_range)
         check($sformatf("v%0d_stall_backpressure", id), stall_bad, 0);
      if (v.pct == 100 && v.stall_mask == 0 && !is_write && in_range) begin
         check($sformatf("v%0d_b2b_span", id), last_rx - first_rx, BEATS - 1);
         check($sformatf("v%0d_idle_after_last", id), done_iter - last_rx, 1);
      end
      $display("txn %0d cmd=%0d addr=%0d err=%0d wr_beats=%0d rd_beats=%0d reqcount=%0d",
               id, v.cmd, v.addr, err_cycles, got_oram.size(), got_host.size(), ReqCount);
   endtask

   initial begin
      vec_t v;
      int   r;

      //               cmd    addr           pct cdly mask         pat err iss
      vecs[0] = '{2'b00, 32'd5,          100, 4, 8'b0000_0000, 1, 0, 1};
      vecs[1] = '{2'b10, 32'd9,          100, 0, 8'b0010_0100, 1, 0, 1};
      vecs[2] = '{2'b10, 32'd9,          100, 0, 8'b0000_0000, 1, 0, 1};
      vecs[3] = '{2'b00, 32'd1024,       100, 0, 8'b0000_0000, 0, 1, 0};
      vecs[4] = '{2'b10, 32'd2000,       100, 0, 8'b0000_0000, 0, 1, 0};
      vecs[5] = '{2'b01, 32'd1023,        60, 2, 8'b0000_0000, 0, 0, 1};
      vecs[6] = '{2'b11, 32'd0,           50, 1, 8'b0000_0001, 0, 0, 1};
      vecs[7] = '{2'b01, 32'hFFFF_FFFF,   70, 0, 8'b0000_0000, 0, 1, 0};
      vecs[8] = '{2'b11, 32'd1024,        70, 0, 8'b0000_0000, 0, 1, 0};

      // reset held low for three cycles
      Reset = 1'b0;
      idle_inputs();
      repeat (3) tick();
      Reset = 1'b1;
      #1;
      check("reset_outputs",
            {HostCmdReady, CmdValid, DataInValid, ReturnDataReady, HostRDataValid,
             HostRDataLast, HostError, HostWDataReady},
            8'b1000_0000);
      check("reset_reqcount", ReqCount, 16'd0);
      check("reset_cmd_paddr", {Cmd, PAddr}, 34'd0);
      check("reset_hostrdata", HostRData, 64'd0);
      tick();

      for (int i = 0; i < 9; i++) run_request(i, vecs[i]);

      // randomized requests
      for (int i = 0; i < 24; i++) begin
         r            = int'($urandom_range(9));
         v.cmd        = 2'($urandom_range(3));
         v.addr       = (r == 0) ? 32'(NVB + $urandom_range(5000)) : 32'($urandom_range(NVB - 1));
         v.pct        = int'($urandom_range(100, 30));
         v.cmd_delay  = int'($urandom_range(3));
         v.stall_mask = 8'($urandom);
         v.pattern    = 1'b0;
         v.exp_err    = (v.addr >= NVB);
         v.exp_issue  = (v.addr < NVB);
         run_request(100 + i, v);
      end

      // reset in the middle of a write block after 3 beats
      HostCmd = 2'b00; HostAddr = 32'd3; HostCmdValid = 1'b1;
      tick();
      HostCmdValid = 1'b0;
      CmdReady = 1'b1;
      tick();
      check("midrst_cmdvalid", CmdValid, 1'b0);
      CmdReady = 1'b0;
      DataInReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         HostWData = 64'(16'hBE00 + i);
         HostWDataValid = 1'b1;
         tick();
      end
      Reset = 1'b0;
      tick();
      Reset = 1'b1;
      #1;
      check("midrst_idle", {HostCmdReady, CmdValid, DataInValid, HostWDataReady}, 4'b1000);
      check("midrst_reqcount", ReqCount, 16'd0);
      idle_inputs();
      tick();
      model_count = 0;
      v = '{2'b10, 32'd0, 80, 0, 8'b0000_0000, 0, 0, 1};
      run_request(200, v);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // global watchdog so the run always terminates
   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
